// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | axi_rd_arbiter: round-robin 2:1 AXI4 read arbiter with in-order R steering |
// | Revision: 1.0 - initial release                                             |
// +-----------------------------------------------------------------------------+
module axi_rd_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 64,
    parameter int MAX_R_INFLIGHT = 8
) (
    input  logic                  aclk,
    input  logic                  areset,

    input  logic                  s0_axi_arvalid,
    output logic                  s0_axi_arready,
    input  logic [ADDR_WIDTH-1:0] s0_axi_araddr,
    input  logic [7:0]            s0_axi_arlen,
    input  logic [2:0]            s0_axi_arsize,
    input  logic [1:0]            s0_axi_arburst,
    output logic                  s0_axi_rvalid,
    input  logic                  s0_axi_rready,
    output logic [DATA_WIDTH-1:0] s0_axi_rdata,
    output logic [1:0]            s0_axi_rresp,
    output logic                  s0_axi_rlast,

    input  logic                  s1_axi_arvalid,
    output logic                  s1_axi_arready,
    input  logic [ADDR_WIDTH-1:0] s1_axi_araddr,
    input  logic [7:0]            s1_axi_arlen,
    input  logic [2:0]            s1_axi_arsize,
    input  logic [1:0]            s1_axi_arburst,
    output logic                  s1_axi_rvalid,
    input  logic                  s1_axi_rready,
    output logic [DATA_WIDTH-1:0] s1_axi_rdata,
    output logic [1:0]            s1_axi_rresp,
    output logic                  s1_axi_rlast,

    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast
);

    localparam int                c_pw       = $clog2(MAX_R_INFLIGHT);
    localparam int                c_one      = 1;
    localparam int                c_max      = MAX_R_INFLIGHT;
    localparam logic [c_pw-1:0]   c_ptr_one  = c_one[c_pw-1:0];
    localparam logic [c_pw:0]     c_cnt_one  = c_one[c_pw:0];
    localparam logic [c_pw:0]     c_cnt_full = c_max[c_pw:0];

    logic                  ptr_q, ptr_d;
    logic [c_pw-1:0]       wptr_q, wptr_d;
    logic [c_pw-1:0]       rptr_q, rptr_d;
    logic [c_pw:0]         count_q, count_d;
    logic [MAX_R_INFLIGHT-1:0] order_q;
    logic                  m_arvalid_q, m_arvalid_d;
    logic [ADDR_WIDTH-1:0] m_araddr_q;
    logic [7:0]            m_arlen_q;
    logic [2:0]            m_arsize_q;
    logic [1:0]            m_arburst_q;

    logic w_load_en;
    logic w_gnt_id;
    logic w_push;
    logic w_pop;
    logic w_empty;
    logic w_head;

    // Reset gating keeps arready low while areset is held, even with requests pending.
    assign w_load_en = !areset && (!m_arvalid_q || m_axi_arready) && (count_q < c_cnt_full);
    assign w_gnt_id  = (s0_axi_arvalid && s1_axi_arvalid) ? ptr_q : s1_axi_arvalid;
    assign w_push    = w_load_en && (s0_axi_arvalid || s1_axi_arvalid);

    assign s0_axi_arready = w_push && !w_gnt_id;
    assign s1_axi_arready = w_push &&  w_gnt_id;

    assign w_empty = (count_q == '0);
    assign w_head  = order_q[rptr_q];

    assign m_axi_rready  = !w_empty && (w_head ? s1_axi_rready : s0_axi_rready);
    assign s0_axi_rvalid = !w_empty && !w_head && m_axi_rvalid;
    assign s1_axi_rvalid = !w_empty &&  w_head && m_axi_rvalid;
    assign w_pop         = m_axi_rvalid && m_axi_rready && m_axi_rlast;

    assign s0_axi_rdata = m_axi_rdata;
    assign s0_axi_rresp = m_axi_rresp;
    assign s0_axi_rlast = m_axi_rlast;
    assign s1_axi_rdata = m_axi_rdata;
    assign s1_axi_rresp = m_axi_rresp;
    assign s1_axi_rlast = m_axi_rlast;

    assign m_axi_arvalid = m_arvalid_q;
    assign m_axi_araddr  = m_araddr_q;
    assign m_axi_arlen   = m_arlen_q;
    assign m_axi_arsize  = m_arsize_q;
    assign m_axi_arburst = m_arburst_q;

    always_comb begin
        ptr_d       = ptr_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        m_arvalid_d = m_arvalid_q;
        if (m_axi_arready) begin
            m_arvalid_d = 1'b0;
        end
        if (w_push) begin
            ptr_d       = !w_gnt_id;
            wptr_d      = wptr_q + c_ptr_one;
            m_arvalid_d = 1'b1;
        end
        if (w_pop) begin
            rptr_d = rptr_q + c_ptr_one;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_cnt_one;
            2'b01:   count_d = count_q - c_cnt_one;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            ptr_q       <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            order_q     <= '0;
            m_arvalid_q <= 1'b0;
            m_araddr_q  <= '0;
            m_arlen_q   <= '0;
            m_arsize_q  <= '0;
            m_arburst_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            m_arvalid_q <= m_arvalid_d;
            if (w_push) begin
                order_q[wptr_q] <= w_gnt_id;
                m_araddr_q      <= w_gnt_id ? s1_axi_araddr  : s0_axi_araddr;
                m_arlen_q       <= w_gnt_id ? s1_axi_arlen   : s0_axi_arlen;
                m_arsize_q      <= w_gnt_id ? s1_axi_arsize  : s0_axi_arsize;
                m_arburst_q     <= w_gnt_id ? s1_axi_arburst : s0_axi_arburst;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_axi_rd_arbiter: directed and randomized bench with a queue-based model  |
// | Revision: 1.0 - initial release                                             |
// +-----------------------------------------------------------------------------+
module tb_axi_rd_arbiter;

    localparam int MAXR = 8;

    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic [1:0]  s_arvalid = '0;
    logic [31:0] s_araddr [2] = '{default: '0};
    logic [7:0]  s_arlen  [2] = '{default: '0};
    logic [2:0]  s_arsize [2] = '{default: '0};
    logic [1:0]  s_arburst[2] = '{default: '0};
    logic [1:0]  s_rready = '0;
    logic        m_arready = 1'b0;
    logic        m_rvalid = 1'b0;
    logic [63:0] m_rdata = '0;
    logic [1:0]  m_rresp = '0;
    logic        m_rlast = 1'b0;

    logic        s0_arready, s1_arready, s0_rvalid, s1_rvalid, s0_rlast, s1_rlast;
    logic [63:0] s0_rdata, s1_rdata;
    logic [1:0]  s0_rresp, s1_rresp;
    logic        m_arvalid, m_rready;
    logic [31:0] m_araddr;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;

    axi_rd_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .MAX_R_INFLIGHT(MAXR)) dut (
        .aclk(clk), .areset(areset),
        .s0_axi_arvalid(s_arvalid[0]), .s0_axi_arready(s0_arready),
        .s0_axi_araddr(s_araddr[0]), .s0_axi_arlen(s_arlen[0]),
        .s0_axi_arsize(s_arsize[0]), .s0_axi_arburst(s_arburst[0]),
        .s0_axi_rvalid(s0_rvalid), .s0_axi_rready(s_rready[0]),
        .s0_axi_rdata(s0_rdata), .s0_axi_rresp(s0_rresp), .s0_axi_rlast(s0_rlast),
        .s1_axi_arvalid(s_arvalid[1]), .s1_axi_arready(s1_arready),
        .s1_axi_araddr(s_araddr[1]), .s1_axi_arlen(s_arlen[1]),
        .s1_axi_arsize(s_arsize[1]), .s1_axi_arburst(s_arburst[1]),
        .s1_axi_rvalid(s1_rvalid), .s1_axi_rready(s_rready[1]),
        .s1_axi_rdata(s1_rdata), .s1_axi_rresp(s1_rresp), .s1_axi_rlast(s1_rlast),
        .m_axi_arvalid(m_arvalid), .m_axi_arready(m_arready),
        .m_axi_araddr(m_araddr), .m_axi_arlen(m_arlen),
        .m_axi_arsize(m_arsize), .m_axi_arburst(m_arburst),
        .m_axi_rvalid(m_rvalid), .m_axi_rready(m_rready),
        .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp), .m_axi_rlast(m_rlast)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: outstanding grants as a queue of requester ids, plus the AR slot.
    int          q[$];
    bit          mv = 0;
    logic [31:0] ma = '0;
    logic [7:0]  ml = '0;
    logic [2:0]  ms = '0;
    logic [1:0]  mb = '0;
    int          rr = 0;
    bit          d_gnt = 0, d_rhs = 0, d_pop = 0, d_arhs = 0;
    int          d_id = 0;

    // Downstream slave and upstream master state driven by the bench.
    int          sq[$];
    int          sbeat = 0;
    bit          r_taken = 0;
    bit          req_taken [2] = '{default: 0};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete(); sq.delete();
        mv = 0; ma = '0; ml = '0; ms = '0; mb = '0; rr = 0;
        sbeat = 0; r_taken = 0; req_taken[0] = 0; req_taken[1] = 0;
        d_gnt = 0; d_rhs = 0; d_pop = 0; d_arhs = 0;
    endtask

    always @(negedge clk) begin
        bit ok;
        int id, h;
        ok = !areset && (!mv || m_arready) && (q.size() < MAXR);
        id = (s_arvalid == 2'b11) ? rr : (s_arvalid[1] ? 1 : 0);
        d_gnt = ok && (s_arvalid != 2'b00);
        d_id  = id;
        h = (q.size() > 0) ? q[0] : -1;
        chk("s0_arready", s0_arready, d_gnt && id == 0);
        chk("s1_arready", s1_arready, d_gnt && id == 1);
        chk("m_arvalid", m_arvalid, mv);
        chk("m_araddr", m_araddr, ma);
        chk("m_arlen", m_arlen, ml);
        chk("m_arsize", m_arsize, ms);
        chk("m_arburst", m_arburst, mb);
        chk("m_rready", m_rready, h >= 0 && s_rready[h]);
        chk("s0_rvalid", s0_rvalid, h == 0 && m_rvalid);
        chk("s1_rvalid", s1_rvalid, h == 1 && m_rvalid);
        chk("s0_rdata", s0_rdata, m_rdata);
        chk("s1_rdata", s1_rdata, m_rdata);
        chk("rresp", {s1_rresp, s0_rresp}, {m_rresp, m_rresp});
        chk("rlast", {s1_rlast, s0_rlast}, {m_rlast, m_rlast});
        d_rhs  = m_rvalid && h >= 0 && s_rready[h];
        d_pop  = d_rhs && m_rlast;
        d_arhs = !areset && mv && m_arready;
    end

    always @(posedge clk) begin
        if (!areset) begin
            if (d_arhs) begin
                sq.push_back(int'(ml));
                mv = 0;
            end
            if (d_pop) void'(q.pop_front());
            if (d_gnt) begin
                q.push_back(d_id);
                mv = 1;
                ma = s_araddr[d_id]; ml = s_arlen[d_id];
                ms = s_arsize[d_id]; mb = s_arburst[d_id];
                rr = 1 - d_id;
                req_taken[d_id] = 1;
            end
            if (d_rhs) r_taken = 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic assert_reset();
        areset = 1'b1;
        model_clear();
        #1;
        chk("rst m_arvalid", m_arvalid, 0);
        chk("rst m_ar payload", {m_araddr, m_arlen, m_arsize, m_arburst}, 0);
        chk("rst arready", {s1_arready, s0_arready}, 0);
        chk("rst rvalid", {s1_rvalid, s0_rvalid}, 0);
        chk("rst m_rready", m_rready, 0);
    endtask

    task automatic do_reset();
        tick();
        assert_reset();
        s_arvalid = '0; m_rvalid = 1'b0; m_rlast = 1'b0; m_arready = 1'b0; s_rready = '0;
        tick();
        tick();
        areset = 1'b0;
    endtask

    task automatic set_req(input int n, input logic [31:0] a, input logic [7:0] l);
        s_arvalid[n] = 1'b1; s_araddr[n] = a; s_arlen[n] = l;
        s_arsize[n] = 3'd3; s_arburst[n] = 2'd1;
    endtask

    task automatic rand_drive(input int rp, input int ap);
        for (int n = 0; n < 2; n++) begin
            if (req_taken[n]) begin
                req_taken[n] = 0;
                s_arvalid[n] = 1'b0;
            end
            if (!s_arvalid[n] && $urandom_range(0, 99) < 60) begin
                s_arvalid[n] = 1'b1;
                s_araddr[n]  = $urandom;
                s_arlen[n]   = 8'($urandom_range(0, 3));
                s_arsize[n]  = 3'($urandom);
                s_arburst[n] = 2'($urandom);
            end
        end
        m_arready = ($urandom_range(0, 99) < ap);
        if (r_taken) begin
            r_taken  = 0;
            m_rvalid = 1'b0;
            if (m_rlast) begin
                void'(sq.pop_front());
                sbeat = 0;
            end else begin
                sbeat++;
            end
        end
        if (!m_rvalid && sq.size() > 0 && $urandom_range(0, 99) < rp) begin
            m_rvalid = 1'b1;
            m_rdata  = {$urandom, $urandom};
            m_rresp  = 2'($urandom);
            m_rlast  = (sbeat == sq[0]);
        end
        s_rready = 2'($urandom);
    endtask

    initial begin
        do_reset();

        // Single read from s0.
        set_req(0, 32'h1000, 8'd3);
        m_arready = 1'b1;
        #1;
        chk("t1 s0_arready", s0_arready, 1);
        chk("t1 s1_arready", s1_arready, 0);
        tick();
        s_arvalid = '0;
        #1;
        chk("t1 m_arvalid", m_arvalid, 1);
        chk("t1 m_araddr", m_araddr, 32'h1000);
        chk("t1 m_arlen", m_arlen, 3);
        tick();
        chk("t1 m_arvalid clr", m_arvalid, 0);
        for (int b = 0; b < 4; b++) begin
            m_rvalid = 1'b1; m_rdata = 64'(b + 16); m_rlast = (b == 3); s_rready = 2'b11;
            #1;
            chk("t1 s0_rvalid", s0_rvalid, 1);
            chk("t1 s1_rvalid", s1_rvalid, 0);
            chk("t1 s0_rdata", s0_rdata, 64'(b + 16));
            tick();
        end
        m_rvalid = 1'b1; m_rlast = 1'b1;
        #1;
        chk("t1 empty m_rready", m_rready, 0);
        chk("t1 empty s0_rvalid", s0_rvalid, 0);
        m_rvalid = 1'b0;

        // Contention: alternating grants, bursts return in grant order.
        do_reset();
        set_req(0, 32'h2000, 8'd0);
        set_req(1, 32'h3000, 8'd0);
        m_arready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("t2 s0 grant", s0_arready, (i % 2) == 0);
            chk("t2 s1 grant", s1_arready, (i % 2) == 1);
            tick();
        end
        s_arvalid = '0;
        tick();
        for (int i = 0; i < 6; i++) begin
            m_rvalid = 1'b1; m_rlast = 1'b1; s_rready = 2'b11;
            #1;
            chk("t2 s0 steer", s0_rvalid, (i % 2) == 0);
            chk("t2 s1 steer", s1_rvalid, (i % 2) == 1);
            tick();
        end
        m_rvalid = 1'b0;

        // Full order FIFO.
        do_reset();
        set_req(0, 32'h4000, 8'd0);
        m_arready = 1'b1;
        repeat (8) tick();
        chk("t3 full stall", s0_arready, 0);
        tick();
        chk("t3 full stall2", s0_arready, 0);
        m_rvalid = 1'b1; m_rlast = 1'b1; s_rready = 2'b01;
        #1;
        chk("t3 pop no relax", s0_arready, 0);
        chk("t3 pop rvalid", s0_rvalid, 1);
        tick();
        m_rvalid = 1'b0;
        #1;
        chk("t3 resume", s0_arready, 1);
        tick();
        chk("t3 full again", s0_arready, 0);
        s_arvalid = '0;

        // AR and R backpressure.
        do_reset();
        m_arready = 1'b0;
        set_req(1, 32'hA000, 8'd0);
        tick();
        s_arvalid = '0;
        set_req(0, 32'hB000, 8'd0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t4 no grant", s0_arready, 0);
            chk("t4 addr stable", m_araddr, 32'hA000);
            chk("t4 arvalid held", m_arvalid, 1);
            tick();
        end
        m_arready = 1'b1;
        #1;
        chk("t4 reload", s0_arready, 1);
        tick();
        s_arvalid = '0;
        tick();
        m_rvalid = 1'b1; m_rlast = 1'b1; s_rready = 2'b01;
        #1;
        chk("t4 m_rready held", m_rready, 0);
        chk("t4 s0 blocked", s0_rvalid, 0);
        chk("t4 s1 head", s1_rvalid, 1);
        tick();
        s_rready = 2'b11;
        #1;
        chk("t4 m_rready go", m_rready, 1);
        tick();
        m_rvalid = 1'b0;

        // Reset in the middle of a burst.
        do_reset();
        set_req(0, 32'hC000, 8'd7);
        m_arready = 1'b1;
        tick();
        s_arvalid = '0;
        tick();
        for (int b = 0; b < 2; b++) begin
            m_rvalid = 1'b1; m_rlast = 1'b0; s_rready = 2'b11;
            tick();
        end
        #1;
        chk("t5 beat2 rvalid", s0_rvalid, 1);
        assert_reset();
        m_rvalid = 1'b0; s_rready = '0; m_arready = 1'b0;
        tick();
        tick();
        areset = 1'b0;
        set_req(1, 32'hD000, 8'd1);
        m_arready = 1'b1;
        #1;
        chk("t5 s1 grant", s1_arready, 1);
        tick();
        s_arvalid = '0;
        #1;
        chk("t5 s1 addr", m_araddr, 32'hD000);

        // Randomized traffic with shifting R and AR rates and a reset mid-stream.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            case (c / 1000)
                0:       rand_drive(70, 80);
                1:       rand_drive(10, 90);
                2:       rand_drive(80, 30);
                default: rand_drive(95, 100);
            endcase
            if (c == 2500) begin
                assert_reset();
                s_arvalid = '0; m_rvalid = 1'b0; m_rlast = 1'b0;
                tick();
                areset = 1'b0;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Two-requester read-channel arbiter that shares one single-ID AXI4 read port between two upstream masters. It sits behind the ID-stripping stage, where the downstream slave sees only one ID and therefore returns read data strictly in AR-issue order. The block round-robins AR requests onto a registered master AR stage and records each grant in an order FIFO. R beats are steered back to the originating requester using the head of that FIFO.

## Interface
- ADDR_WIDTH, 32, address width of all AR channels
- DATA_WIDTH, 64, R data width
- MAX_R_INFLIGHT, 8, maximum accepted-but-uncompleted read bursts; power of two, ≥2

- aclk  in  1  clock; all logic on rising edge
- areset  in  1  asynchronous, active-high reset
- sN_axi_arvalid / sN_axi_arready  in / out  1  requester N AR handshake (N = 0, 1)
- sN_axi_araddr  in  ADDR_WIDTH  requester N address
- sN_axi_arlen / sN_axi_arsize / sN_axi_arburst  in  8 / 3 / 2  requester N burst attributes
- sN_axi_rvalid / sN_axi_rready  out / in  1  requester N R handshake
- sN_axi_rdata / sN_axi_rresp / sN_axi_rlast  out  DATA_WIDTH / 2 / 1  requester N R payload
- m_axi_arvalid / m_axi_arready  out / in  1  downstream AR handshake
- m_axi_araddr / m_axi_arlen / m_axi_arsize / m_axi_arburst  out  ADDR_WIDTH / 8 / 3 / 2  registered AR payload
- m_axi_rvalid / m_axi_rready  in / out  1  downstream R handshake
- m_axi_rdata / m_axi_rresp / m_axi_rlast  in  DATA_WIDTH / 2 / 1  downstream R payload

## Operation
- AR stage register:
  - load_en = (!m_axi_arvalid || m_axi_arready) && (count < MAX_R_INFLIGHT).
  - The pop condition in the same cycle does not relax the full check.
- Arbitration:
  - When load_en is high and at least one sN_axi_arvalid is high, grant one requester.
  - Round-robin pointer ptr resets to 0. If both requesters are valid, grant ptr. If only one is valid, grant that one.
  - After a grant to i, ptr = 1-i. With no grant, ptr holds.
- Grant actions (same cycle):
  - sI_axi_arready = 1 for the granted requester only. It is combinational from load_en and the arbitration result.
  - Capture the granted AR fields into the m_axi_ar* registers. Set m_axi_arvalid = 1.
  - Push i into the order FIFO; count increments.
- m_axi_arvalid:
  - Holds with a stable payload until m_axi_arready.
  - Clears after the handshake unless a new grant reloads it in the same cycle. Back-to-back reloads sustain 1 AR/cycle.
- Order FIFO:
  - Depth MAX_R_INFLIGHT, 1-bit entries.
  - Read/write pointers are log2(MAX_R_INFLIGHT) bits and wrap naturally.
  - count is log2(MAX_R_INFLIGHT)+1 bits, range 0..MAX_R_INFLIGHT.
- R steering (combinational):
  - If the FIFO is non-empty with head h: sH_axi_rvalid = m_axi_rvalid and m_axi_rready = sH_axi_rready. The non-selected requester's rvalid = 0.
  - rdata/rresp/rlast fan out to both requesters unchanged.
  - If the FIFO is empty: m_axi_rready = 0 and both sN_axi_rvalid = 0.
- Pop on (m_axi_rvalid && m_axi_rready && m_axi_rlast). Non-last beats do not pop.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Reset, asserted at any time, including mid-burst:
  - Clears ptr, FIFO pointers, count and m_axi_arvalid immediately.
  - In-flight bursts are abandoned; no recovery is attempted.

## Timing
- Output values while areset is asserted, and after it deasserts until the first grant:
  - m_axi_arvalid = 0; m_axi_ar* payload = 0.
  - s0/s1_axi_arready = 0, s0/s1_axi_rvalid = 0, m_axi_rready = 0.
- AR latency: a requester handshake at edge k gives m_axi_arvalid = 1 after edge k.
- R latency: 0 cycles, combinational passthrough.
- Full FIFO (count == MAX_R_INFLIGHT): both sN_axi_arready = 0. Grants resume the cycle after a last-beat pop.
- m_axi_arready held low: the AR register stalls, no new grants occur, and requester arvalid is left pending.
- No combinational path from any sN_axi_arvalid to m_axi_arvalid.

## Test plan
- Single read: s0 AR addr 0x1000, len 3. Response: m_axi_arvalid one cycle later with addr 0x1000, len 3. All 4 R beats reach s0 only, and count returns 0 after rlast.
- Contention:
  - Stimulus: both requesters hold arvalid continuously for 6 grants, with m_axi_arready = 1.
  - Response: grant order s0,s1,s0,s1,s0,s1, one grant per cycle.
  - R bursts (len 0) are returned in that order, and each is steered to the matching requester.
- Full: MAX_R_INFLIGHT = 8, issue 8 ARs with no R returned.
  - Response: the 9th AR stalls with arready = 0.
  - One rlast handshake → 9th AR granted the next cycle; count = 8 again.
- Backpressure:
  - m_axi_arready = 0 for 5 cycles: the m_axi_ar* payload stays stable and no second grant occurs.
  - s1_axi_rready = 0 while the head is s1: m_axi_rready = 0 and the s0 data is not delivered.
- Simultaneous push/pop at count = 4: count stays 4, and FIFO order is preserved across pointer wrap after 20 mixed bursts.
- Reset mid-burst:
  - Stimulus: assert areset during beat 2 of a len-7 burst.
  - Response: all outputs go to 0 at once.
  - After release, a new s1 AR is granted normally (ptr = 0 rule still applied).
